esticador_pulso: RTL and testbench

- Output-side counterpart of the button synchronizer. It takes one-cycle internal event pulses and drives an active-low physical indicator (LED / 7-seg segment) that a human can see.
- Each accepted pulse produces one low period of CICLOS_ATIVO cycles, followed by a high gap of CICLOS_PAUSA cycles.
- Pulses that arrive while busy are queued in a saturating counter and played back in order.
- Sits between the ALU control FSM and the board output pins.

---
 rtl/esticador_pulso_pkg.sv | 19 +
 rtl/esticador_pulso_contador.sv | 33 +++
 rtl/esticador_pulso.sv | 137 +++++++++++++
 tb/tb_esticador_pulso.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esticador_pulso_pkg.sv
// Shared definitions for the pulse stretcher that drives active-low indicators.
//   estado_t            : FSM state encoding (OCIOSO / ATIVO / PAUSA)
//   CICLOS_*_PADRAO     : default period lengths for a 50 MHz clock
package esticador_pulso_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        ATIVO  = 2'b01,
        PAUSA  = 2'b10
    } estado_t;

    // 100 ms lit, 50 ms forced dark gap at 50 MHz
    localparam int CICLOS_ATIVO_PADRAO     = 5000000;
    localparam int CICLOS_PAUSA_PADRAO     = 2500000;
    localparam int MAX_PENDENTES_PADRAO    = 3;
    localparam int LARGURA_CONTADOR_PADRAO = 24;
    localparam int LARGURA_PEND_PADRAO     = 2;

endpackage

// File: rtl/esticador_pulso_contador.sv
// Loadable down-counter that times the lit and gap periods.
//   CLOCK    : system clock
//   RESET    : asynchronous active-low reset, clears the count
//   carga    : load valor on the next edge (has priority over counting)
//   valor    : value to load
//   habilita : decrement while nonzero
//   terminal : high when the count is zero
module contador_periodo #(
    parameter int LARGURA_CONTADOR = 24
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        carga,
    input  logic [LARGURA_CONTADOR-1:0] valor,
    input  logic                        habilita,
    output logic                        terminal
);

    logic [LARGURA_CONTADOR-1:0] contagem;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            contagem <= '0;
        end else if (carga) begin
            contagem <= valor;
        end else if (habilita && (contagem != '0)) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign terminal = (contagem == '0);

endmodule

// File: rtl/esticador_pulso.sv
// Stretches one-cycle internal event pulses into human-visible active-low
// indicator periods: CICLOS_ATIVO cycles low, then CICLOS_PAUSA cycles high.
// Requests arriving while busy are queued (saturating) and replayed in order.
//   CLOCK         : system clock
//   RESET         : asynchronous active-low reset
//   pulso_entrada : one-cycle event request
//   saida_raw     : active-low indicator drive (registered)
//   ocupado       : high while a lit period or its gap is in progress
//   pendentes     : number of queued requests
//   estouro       : one-cycle pulse when a request is dropped (queue full)
module esticador_pulso
    import esticador_pulso_pkg::*;
#(
    parameter int CICLOS_ATIVO     = CICLOS_ATIVO_PADRAO,
    parameter int CICLOS_PAUSA     = CICLOS_PAUSA_PADRAO,
    parameter int MAX_PENDENTES    = MAX_PENDENTES_PADRAO,
    parameter int LARGURA_CONTADOR = LARGURA_CONTADOR_PADRAO,
    parameter int LARGURA_PEND     = LARGURA_PEND_PADRAO
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    pulso_entrada,
    output logic                    saida_raw,
    output logic                    ocupado,
    output logic [LARGURA_PEND-1:0] pendentes,
    output logic                    estouro
);

    localparam logic [LARGURA_CONTADOR-1:0] RECARGA_ATIVO =
        LARGURA_CONTADOR'(CICLOS_ATIVO - 1);
    localparam logic [LARGURA_CONTADOR-1:0] RECARGA_PAUSA =
        LARGURA_CONTADOR'((CICLOS_PAUSA > 0) ? (CICLOS_PAUSA - 1) : 0);
    localparam logic [LARGURA_PEND:0] LIMITE = (LARGURA_PEND + 1)'(MAX_PENDENTES);
    localparam bit TEM_PAUSA = (CICLOS_PAUSA > 0);

    estado_t                     estado;
    logic                        terminal;
    logic                        carga;
    logic [LARGURA_CONTADOR-1:0] valor;
    logic                        inc;
    logic                        fim_intervalo;
    logic                        repete;
    logic                        descarte;
    logic [LARGURA_PEND:0]       efetivo;
    logic [LARGURA_PEND:0]       restante;
    logic [LARGURA_PEND-1:0]     pend_prox;

    contador_periodo #(
        .LARGURA_CONTADOR(LARGURA_CONTADOR)
    ) u_contador (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .carga    (carga),
        .valor    (valor),
        .habilita (estado != OCIOSO),
        .terminal (terminal)
    );

    always_comb begin
        inc     = pulso_entrada && (estado != OCIOSO);
        efetivo = {1'b0, pendentes} + {{LARGURA_PEND{1'b0}}, inc};

        // End-of-gap decision: last PAUSA cycle, or last ATIVO cycle when
        // there is no gap. A request arriving on this very cycle counts.
        fim_intervalo = 1'b0;
        if (terminal) begin
            fim_intervalo = (estado == PAUSA) || ((estado == ATIVO) && !TEM_PAUSA);
        end
        repete = fim_intervalo && (efetivo != '0);

        restante  = efetivo - {{LARGURA_PEND{1'b0}}, repete};
        descarte  = (restante > LIMITE);
        pend_prox = descarte ? LIMITE[LARGURA_PEND-1:0] : restante[LARGURA_PEND-1:0];

        carga = 1'b0;
        valor = RECARGA_ATIVO;
        if (estado == OCIOSO) begin
            carga = pulso_entrada;
        end else if ((estado == ATIVO) && terminal && TEM_PAUSA) begin
            carga = 1'b1;
            valor = RECARGA_PAUSA;
        end else if (repete) begin
            carga = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            estado    <= OCIOSO;
            saida_raw <= 1'b1;
            ocupado   <= 1'b0;
            pendentes <= '0;
            estouro   <= 1'b0;
        end else begin
            pendentes <= pend_prox;
            estouro   <= descarte;
            case (estado)
                OCIOSO: begin
                    if (pulso_entrada) begin
                        estado    <= ATIVO;
                        saida_raw <= 1'b0;
                        ocupado   <= 1'b1;
                    end
                end
                ATIVO: begin
                    if (terminal) begin
                        if (TEM_PAUSA) begin
                            estado    <= PAUSA;
                            saida_raw <= 1'b1;
                        end else if (!repete) begin
                            estado    <= OCIOSO;
                            saida_raw <= 1'b1;
                            ocupado   <= 1'b0;
                        end
                    end
                end
                PAUSA: begin
                    if (terminal) begin
                        if (repete) begin
                            estado    <= ATIVO;
                            saida_raw <= 1'b0;
                        end else begin
                            estado  <= OCIOSO;
                            ocupado <= 1'b0;
                        end
                    end
                end
                default: begin
                    estado    <= OCIOSO;
                    saida_raw <= 1'b1;
                    ocupado   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esticador_pulso.sv
module tb_esticador_pulso;

    localparam int CA = 4;
    localparam int CP = 2;
    localparam int MX = 3;
    localparam int LC = 24;
    localparam int LP = 2;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          pulso = 1'b0;
    logic          saida_a, ocupado_a, estouro_a;
    logic [LP-1:0] pend_a;
    logic          saida_b, ocupado_b, estouro_b;
    logic [LP-1:0] pend_b;

    esticador_pulso #(
        .CICLOS_ATIVO(CA), .CICLOS_PAUSA(CP), .MAX_PENDENTES(MX),
        .LARGURA_CONTADOR(LC), .LARGURA_PEND(LP)
    ) dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .pulso_entrada(pulso),
        .saida_raw(saida_a), .ocupado(ocupado_a), .pendentes(pend_a), .estouro(estouro_a)
    );

    esticador_pulso #(
        .CICLOS_ATIVO(CA), .CICLOS_PAUSA(0), .MAX_PENDENTES(MX),
        .LARGURA_CONTADOR(LC), .LARGURA_PEND(LP)
    ) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .pulso_entrada(pulso),
        .saida_raw(saida_b), .ocupado(ocupado_b), .pendentes(pend_b), .estouro(estouro_b)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;
    int ciclo_n  = 0;

    // Reference model: r = cycles left in the current busy burst (lit + gap),
    // q = queued requests. Lit while r > gap length.
    int r_a = 0, q_a = 0, r_b = 0, q_b = 0;
    bit d_a = 0, d_b = 0;

    function automatic void passo(input int cp, input bit p,
                                  inout int r, inout int q, output bit drop);
        int eff;
        drop = 1'b0;
        if (r == 0) begin
            if (p) r = CA + cp;
            return;
        end
        eff = q + (p ? 1 : 0);
        if (r == 1 && eff > 0) begin
            r = CA + cp;
            eff = eff - 1;
        end else begin
            r = r - 1;
        end
        if (eff > MX) begin
            drop = 1'b1;
            eff  = MX;
        end
        q = eff;
    endfunction

    function automatic logic [4:0] esperado(input int r, input int q, input bit d, input int cp);
        return {(r > cp) ? 1'b0 : 1'b1, (r > 0) ? 1'b1 : 1'b0, 2'(q), d};
    endfunction

    task automatic ciclo(input bit p);
        pulso = p;
        @(posedge CLOCK);
        passo(CP, p, r_a, q_a, d_a);
        passo(0, p, r_b, q_b, d_b);
        ciclo_n++;
        #1;
        pulso = 1'b0;
    endtask

    task automatic reset_modelo();
        r_a = 0; q_a = 0; d_a = 0;
        r_b = 0; q_b = 0; d_b = 0;
    endtask

    task automatic aguarda_ocioso();
        int n = 0;
        while ((r_a != 0 || r_b != 0) && n < 60) begin
            ciclo(1'b0);
            n++;
        end
        ciclo(1'b0);
        checks++;
        if (ocupado_a !== 1'b0 || ocupado_b !== 1'b0) begin
            failures++;
            $display("FAIL settle_idle: ocupado_a=%b ocupado_b=%b required 0 0", ocupado_a, ocupado_b);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        reset_modelo();
        #12;
        checks++;
        if ({saida_a, ocupado_a, pend_a, estouro_a} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_a: got %b required %b", {saida_a, ocupado_a, pend_a, estouro_a}, 5'b10000);
        end
        checks++;
        if ({saida_b, ocupado_b, pend_b, estouro_b} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_b: got %b required %b", {saida_b, ocupado_b, pend_b, estouro_b}, 5'b10000);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (3) ciclo(1'b0);
    endtask

    task automatic test_pulso_unico();
        int baixos = 0;
        for (int i = 0; i < 12; i++) begin
            ciclo(i == 0);
            if (saida_a === 1'b0) baixos++;
            checks++;
            if ({saida_a, ocupado_a, pend_a, estouro_a} !== esperado(r_a, q_a, d_a, CP)) begin
                failures++;
                $display("FAIL single_a cyc=%0d: got %b required %b", i,
                         {saida_a, ocupado_a, pend_a, estouro_a}, esperado(r_a, q_a, d_a, CP));
            end
        end
        checks++;
        if (baixos != CA) begin
            failures++;
            $display("FAIL single_low_len: got %0d required %0d", baixos, CA);
        end
    endtask

    task automatic test_fila();
        int janelas = 0;
        int maxq = 0;
        logic ant = 1'b1;
        for (int i = 0; i < 22; i++) begin
            ciclo(i == 0 || i == 2 || i == 3);
            if (ant === 1'b1 && saida_a === 1'b0) janelas++;
            ant = saida_a;
            if (int'(pend_a) > maxq) maxq = int'(pend_a);
            checks++;
            if ({saida_a, ocupado_a, pend_a, estouro_a} !== esperado(r_a, q_a, d_a, CP)) begin
                failures++;
                $display("FAIL queue_a cyc=%0d: got %b required %b", i,
                         {saida_a, ocupado_a, pend_a, estouro_a}, esperado(r_a, q_a, d_a, CP));
            end
        end
        checks++;
        if (janelas != 3 || maxq != 2) begin
            failures++;
            $display("FAIL queue_windows: got windows=%0d maxq=%0d required 3 2", janelas, maxq);
        end
    endtask

    task automatic test_estouro();
        int janelas = 0;
        int drops = 0;
        logic ant = 1'b1;
        for (int i = 0; i < 34; i++) begin
            ciclo(i < 6);
            if (ant === 1'b1 && saida_a === 1'b0) janelas++;
            ant = saida_a;
            if (estouro_a === 1'b1) drops++;
            checks++;
            if ({saida_a, ocupado_a, pend_a, estouro_a} !== esperado(r_a, q_a, d_a, CP)) begin
                failures++;
                $display("FAIL overflow_a cyc=%0d: got %b required %b", i,
                         {saida_a, ocupado_a, pend_a, estouro_a}, esperado(r_a, q_a, d_a, CP));
            end
            checks++;
            if ({saida_b, ocupado_b, pend_b, estouro_b} !== esperado(r_b, q_b, d_b, 0)) begin
                failures++;
                $display("FAIL overflow_b cyc=%0d: got %b required %b", i,
                         {saida_b, ocupado_b, pend_b, estouro_b}, esperado(r_b, q_b, d_b, 0));
            end
        end
        checks++;
        if (janelas != 4 || drops != 2) begin
            failures++;
            $display("FAIL overflow_counts: got windows=%0d drops=%0d required 4 2", janelas, drops);
        end
    endtask

    task automatic test_ultimo_ciclo_pausa();
        for (int i = 0; i < 7; i++) ciclo(i == 0 || i == 6);
        checks++;
        if ({saida_a, ocupado_a, pend_a, estouro_a} !== 5'b01000) begin
            failures++;
            $display("FAIL last_gap_replay: got %b required %b", {saida_a, ocupado_a, pend_a, estouro_a}, 5'b01000);
        end
        checks++;
        if ({saida_a, ocupado_a, pend_a, estouro_a} !== esperado(r_a, q_a, d_a, CP)) begin
            failures++;
            $display("FAIL last_gap_model: got %b required %b",
                     {saida_a, ocupado_a, pend_a, estouro_a}, esperado(r_a, q_a, d_a, CP));
        end
    endtask

    task automatic test_reset_assincrono();
        int baixos = 0;
        for (int i = 0; i < 3; i++) ciclo(1'b1);
        checks++;
        if (saida_a !== 1'b0 || pend_a !== 2'd2) begin
            failures++;
            $display("FAIL async_setup: saida=%b pend=%0d required 0 2", saida_a, pend_a);
        end
        #2;
        RESET = 1'b0;
        reset_modelo();
        #1;
        checks++;
        if ({saida_a, ocupado_a, pend_a, estouro_a} !== 5'b10000) begin
            failures++;
            $display("FAIL async_reset_a: got %b required %b", {saida_a, ocupado_a, pend_a, estouro_a}, 5'b10000);
        end
        checks++;
        if ({saida_b, ocupado_b, pend_b, estouro_b} !== 5'b10000) begin
            failures++;
            $display("FAIL async_reset_b: got %b required %b", {saida_b, ocupado_b, pend_b, estouro_b}, 5'b10000);
        end
        @(negedge CLOCK);
        RESET = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ciclo(1'b0);
            if (saida_a === 1'b0 || saida_b === 1'b0) baixos++;
        end
        checks++;
        if (baixos != 0) begin
            failures++;
            $display("FAIL async_no_replay: got %0d lit cycles required 0", baixos);
        end
    endtask

    task automatic test_pausa_zero();
        int baixos = 0;
        int janelas = 0;
        logic ant = 1'b1;
        for (int i = 0; i < 14; i++) begin
            ciclo(i == 0 || i == 1);
            if (saida_b === 1'b0) baixos++;
            if (ant === 1'b1 && saida_b === 1'b0) janelas++;
            ant = saida_b;
            checks++;
            if ({saida_b, ocupado_b, pend_b, estouro_b} !== esperado(r_b, q_b, d_b, 0)) begin
                failures++;
                $display("FAIL no_gap_b cyc=%0d: got %b required %b", i,
                         {saida_b, ocupado_b, pend_b, estouro_b}, esperado(r_b, q_b, d_b, 0));
            end
        end
        checks++;
        if (baixos != 2 * CA || janelas != 1) begin
            failures++;
            $display("FAIL no_gap_shape: got low=%0d runs=%0d required %0d 1", baixos, janelas, 2 * CA);
        end
    endtask

    task automatic test_aleatorio();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2;
                RESET = 1'b0;
                reset_modelo();
                @(negedge CLOCK);
                RESET = 1'b1;
            end
            ciclo($urandom_range(0, 3) == 0);
            checks++;
            if ({saida_a, ocupado_a, pend_a, estouro_a} !== esperado(r_a, q_a, d_a, CP)) begin
                failures++;
                $display("FAIL random_a cyc=%0d: got %b required %b", ciclo_n,
                         {saida_a, ocupado_a, pend_a, estouro_a}, esperado(r_a, q_a, d_a, CP));
            end
            checks++;
            if ({saida_b, ocupado_b, pend_b, estouro_b} !== esperado(r_b, q_b, d_b, 0)) begin
                failures++;
                $display("FAIL random_b cyc=%0d: got %b required %b", ciclo_n,
                         {saida_b, ocupado_b, pend_b, estouro_b}, esperado(r_b, q_b, d_b, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulso_unico();
        aguarda_ocioso();
        test_fila();
        aguarda_ocioso();
        test_estouro();
        aguarda_ocioso();
        test_ultimo_ciclo_pausa();
        aguarda_ocioso();
        test_reset_assincrono();
        test_pausa_zero();
        aguarda_ocioso();
        test_aleatorio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
